// File: rtl/dm_pkg.sv
// dm_pkg: shared encodings, initial memory image and lane helpers for datamemory_be.
//   SIZE_*      access size encodings (2'b11 is treated as a word access)
//   WR / RD     direction encodings on the WR_RD input
//   INIT_WORD*  contents of physical words 0..3 before any store
//   stage_t     payload carried by each read pipeline stage
package dm_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic WR = 1'b0;
    localparam logic RD = 1'b1;

    localparam logic [31:0] INIT_WORD0 = 32'd2001;
    localparam logic [31:0] INIT_WORD1 = 32'd4001;
    localparam logic [31:0] INIT_WORD2 = 32'd5001;
    localparam logic [31:0] INIT_WORD3 = 32'd3001;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
        logic [1:0]  offset;
        logic [1:0]  size;
        logic        load_unsigned;
    } stage_t;

    // Lane enables for an aligned store; the reserved size falls into the word branch.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << offset;
            SIZE_HALF: be = offset[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = offset[0];
            default:   mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

    // Right-aligned store data replicated across every lane so the enables alone pick the target.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] din);
        logic [31:0] lanes;
        case (size)
            SIZE_BYTE: lanes = {4{din[7:0]}};
            SIZE_HALF: lanes = {2{din[15:0]}};
            default:   lanes = din;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/dm_load_align.sv
// dm_load_align: picks the addressed lane(s) out of a stored word and extends them to 32 bits.
//   word          stored word captured by the read pipeline
//   offset        byte offset ADDR[1:0] of the access
//   size          access size (byte / half / word, reserved = word)
//   load_unsigned 1 = zero-extend, 0 = sign-extend sub-word loads
//   data          extended load result
module dm_load_align
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[{offset, 3'b000} +: 8];
        lane_h = offset[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: data = {{24{~load_unsigned & lane_b[7]}}, lane_b};
            SIZE_HALF: data = {{16{~load_unsigned & lane_h[15]}}, lane_h};
            default:   data = word;
        endcase
    end

endmodule

// File: rtl/datamemory_be.sv
// datamemory_be: byte-addressed single-port data memory with lane-enabled stores,
// extended sub-word loads, a READ_LATENCY-deep read pipeline and misalignment reporting.
//   clk, rst       clock and synchronous active-high reset (memory contents untouched)
//   req, WR_RD     access request and direction (0 write, 1 read)
//   size           00 byte, 01 half, 10/11 word
//   load_unsigned  zero- instead of sign-extension for sub-word loads
//   ADDR, din      byte address and right-aligned store data
//   dout           load data, held between strobes
//   dout_valid     one-cycle strobe for a completed read
//   misalign_err   one-cycle strobe for a rejected misaligned access
module datamemory_be
    import dm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned BASE_OFFSET  = 0,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  WR_RD,
    input  logic [1:0]            size,
    input  logic                  load_unsigned,
    input  logic [ADDR_WIDTH+1:0] ADDR,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  misalign_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] OFFSET = ADDR_WIDTH'(BASE_OFFSET % DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{
        0: INIT_WORD0, 1: INIT_WORD1, 2: INIT_WORD2, 3: INIT_WORD3, default: '0
    };

    logic [ADDR_WIDTH-1:0] idx;
    logic                  mis;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  we;
    stage_t                stage_in;
    stage_t                pipe_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] hold_q;

    // Index wraps silently through the natural truncation of the sum.
    assign idx   = ADDR[ADDR_WIDTH+1:2] + OFFSET;
    assign mis   = is_misaligned(size, ADDR[1:0]);
    assign be    = byte_en(size, ADDR[1:0]);
    assign wdata = store_lanes(size, din);
    assign we    = req && !rst && (WR_RD == WR) && !mis;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Stage 1 captures the word before any write at this edge lands, so a later
    // write never disturbs a read already in flight.
    always_comb begin
        stage_in               = '0;
        stage_in.valid         = req && (WR_RD == RD) && !mis;
        stage_in.err           = req && mis;
        stage_in.data          = mem[idx];
        stage_in.offset        = ADDR[1:0];
        stage_in.size          = size;
        stage_in.load_unsigned = load_unsigned;
    end

    always_ff @(posedge clk) begin
        pipe_q[0] <= stage_in;
        for (int unsigned s = 1; s < READ_LATENCY; s++) begin
            pipe_q[s] <= pipe_q[s-1];
        end
        if (rst) begin
            for (int unsigned s = 0; s < READ_LATENCY; s++) begin
                pipe_q[s].valid <= 1'b0;
                pipe_q[s].err   <= 1'b0;
            end
        end
    end

    dm_load_align u_load_align (
        .word          (pipe_q[READ_LATENCY-1].data),
        .offset        (pipe_q[READ_LATENCY-1].offset),
        .size          (pipe_q[READ_LATENCY-1].size),
        .load_unsigned (pipe_q[READ_LATENCY-1].load_unsigned),
        .data          (load_data)
    );

    assign dout_valid   = pipe_q[READ_LATENCY-1].valid;
    assign misalign_err = pipe_q[READ_LATENCY-1].err;

    // Error strobes force zero; otherwise dout keeps the last delivered load.
    always_comb begin
        if (dout_valid) begin
            dout = load_data;
        end else if (misalign_err) begin
            dout = '0;
        end else begin
            dout = hold_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else if (dout_valid) begin
            hold_q <= load_data;
        end
    end

endmodule
